// File: rtl/token_div_sched_if.sv
// token_div_sched_if: requester token bus and result handshake
// shared between the scheduler and its clients.
interface token_div_sched_if #(
  parameter int NREQ = 4
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][12:0] req_dividend;
  logic [NREQ-1:0][6:0]  req_divisor;
  logic [NREQ-1:0]       req_sign;
  logic [NREQ-1:0][4:0]  req_addr;
  logic [NREQ-1:0][6:0]  req_zerozero;

  logic                  res_valid;
  logic [4:0]            res_addr;
  logic signed [6:0]     res_delta;
  logic [SW-1:0]         res_src;
  logic                  res_ready;

  modport master (
    output req_valid,
    output req_dividend,
    output req_divisor,
    output req_sign,
    output req_addr,
    output req_zerozero,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_addr,
    input  res_delta,
    input  res_src
  );

  modport slave (
    input  req_valid,
    input  req_dividend,
    input  req_divisor,
    input  req_sign,
    input  req_addr,
    input  req_zerozero,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_addr,
    output res_delta,
    output res_src
  );
endinterface

// File: rtl/token_div_sched.sv
// token_div_sched: round-robin scheduler that hands one token
// request at a time to a shared divider and returns its delta.
module token_div_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clock,
  input  logic              rst,
  token_div_sched_if.slave  bus,
  output logic [12:0]       div_divider,
  output logic [6:0]        div_divisor,
  output logic              div_flag_start,
  output logic              div_sign,
  output logic [4:0]        div_addr,
  output logic [6:0]        div_zerozero,
  output logic              div_freeze,
  input  logic              div_packet_out,
  input  logic [4:0]        div_packet_out_addr,
  input  logic signed [6:0] div_token_delta,
  output logic              timeout_err,
  output logic              busy
);

  localparam int SW = $clog2(NREQ);
  localparam logic [SW-1:0] LAST = SW'(NREQ - 1);
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  state_t        state;
  logic [7:0]    timer;
  logic [SW-1:0] last_grant;
  logic [SW-1:0] src;
  logic [SW-1:0] gnt_idx;
  logic [SW-1:0] scan;
  logic          gnt_hit;
  logic          pkt_hit;
  logic          tmo;

  // round-robin search starting just after the last grant
  always_comb begin
    gnt_hit = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan = SW'((int'(last_grant) + k) % NREQ);
      if (!gnt_hit && bus.req_valid[scan]) begin
        gnt_hit = 1'b1;
        gnt_idx = scan;
      end
    end
  end

  // one-hot accept, only in the IDLE grant cycle and out of reset
  always_comb begin
    bus.req_ready = '0;
    if (rst && state == IDLE && gnt_hit) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  assign pkt_hit = div_packet_out &&
                   (div_packet_out_addr == div_addr);
  assign tmo     = (timer == TLIM);

  // scheduler FSM with registered divider/result outputs
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      timer          <= '0;
      last_grant     <= LAST;
      src            <= '0;
      div_divider    <= '0;
      div_divisor    <= '0;
      div_sign       <= 1'b0;
      div_addr       <= '0;
      div_zerozero   <= '0;
      div_flag_start <= 1'b0;
      div_freeze     <= 1'b0;
      bus.res_valid  <= 1'b0;
      bus.res_addr   <= '0;
      bus.res_delta  <= '0;
      bus.res_src    <= '0;
      timeout_err    <= 1'b0;
      busy           <= 1'b0;
    end else begin
      div_flag_start <= 1'b0;
      timeout_err    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (gnt_hit) begin
            last_grant     <= gnt_idx;
            src            <= gnt_idx;
            div_divider    <= bus.req_dividend[gnt_idx];
            div_divisor    <= bus.req_divisor[gnt_idx];
            div_sign       <= bus.req_sign[gnt_idx];
            div_addr       <= bus.req_addr[gnt_idx];
            div_zerozero   <= bus.req_zerozero[gnt_idx];
            div_flag_start <= 1'b1;
            busy           <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (pkt_hit) begin
            bus.res_valid <= 1'b1;
            bus.res_addr  <= div_addr;
            bus.res_delta <= div_token_delta;
            bus.res_src   <= src;
            div_freeze    <= 1'b1;
            state         <= HOLD;
          end else if (tmo) begin
            timeout_err <= 1'b1;
            last_grant  <= src;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            div_freeze    <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
